// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave: spcon bit positions, byte width, FSM states.
package spi_pkg;
    localparam int SPEN   = 0;
    localparam int CPHA   = 1;
    localparam int CPOL   = 2;
    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus rise/fall detect on the synced value.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   q_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= {SYNC_STAGES{RESET_VAL}};
            q_prev <= RESET_VAL;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], d};
            q_prev <= sync[SYNC_STAGES-1];
        end
    end

    assign q    = sync[SYNC_STAGES-1];
    assign rise = q & ~q_prev;
    assign fall = ~q & q_prev;
endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversamples sck/ssn/mosi in the clk domain, shifts one byte each way per 8 sck cycles,
// MSB first, with a one-byte transmit holding register and a received-byte valid pulse.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        spcon,
    input  logic              sck,
    input  logic              ssn,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_abort
);
    logic sck_rise, sck_fall, ssn_rise, ssn_fall, mosi_s;
    logic sck_q_unused, ssn_q_unused, mosi_rise_unused, mosi_fall_unused;
    logic [4:0] spcon_unused;
    assign spcon_unused = spcon[7:3];

    // All three inputs use identical sync depth so their relative alignment is kept.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst_n(rst_n), .d(sck), .q(sck_q_unused), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ssn_sync (
        .clk(clk), .rst_n(rst_n), .d(ssn), .q(ssn_q_unused), .rise(ssn_rise), .fall(ssn_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

    state_e            state_q, state_d;
    logic              cpol_q, cpha_q, need_load;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] rx_shift, tx_shift, hold, load_byte;
    logic              hold_full;
    logic              enter, leave, load;
    logic              lead_edge, trail_edge, sample_edge, shift_edge;

    assign lead_edge   = cpol_q ? sck_fall : sck_rise;
    assign trail_edge  = cpol_q ? sck_rise : sck_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign load_byte   = hold_full ? hold : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        leave   = 1'b0;
        case (state_q)
            IDLE:
                if (ssn_fall && spcon[SPEN]) begin
                    state_d = ACTIVE;
                    enter   = 1'b1;
                end
            ACTIVE:
                if (ssn_rise || !spcon[SPEN]) begin
                    state_d = IDLE;
                    leave   = 1'b1;
                end
            default: state_d = IDLE;
        endcase
        load = enter || (state_q == ACTIVE && !leave && shift_edge && need_load);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            need_load   <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            miso        <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;
            tx_underrun <= load && !hold_full;
            if (enter) begin
                cpol_q    <= spcon[CPOL];
                cpha_q    <= spcon[CPHA];
                bit_cnt   <= '0;
                need_load <= 1'b0;
                // cpha=0 must present the MSB before the first sampling edge.
                if (spcon[CPHA]) begin
                    tx_shift <= load_byte;
                end else begin
                    miso     <= load_byte[BYTE_W-1];
                    tx_shift <= {load_byte[BYTE_W-2:0], 1'b0};
                end
            end else if (leave) begin
                frame_abort <= (bit_cnt != '0);
                bit_cnt     <= '0;
                need_load   <= 1'b0;
                miso        <= 1'b0;
            end else if (state_q == ACTIVE) begin
                if (sample_edge) begin
                    rx_shift <= {rx_shift[BYTE_W-2:0], mosi_s};
                    if (bit_cnt == 3'd7) begin
                        rx_data   <= {rx_shift[BYTE_W-2:0], mosi_s};
                        rx_valid  <= 1'b1;
                        bit_cnt   <= '0;
                        need_load <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                if (shift_edge) begin
                    if (need_load) begin
                        miso      <= load_byte[BYTE_W-1];
                        tx_shift  <= {load_byte[BYTE_W-2:0], 1'b0};
                        need_load <= 1'b0;
                    end else begin
                        miso     <= tx_shift[BYTE_W-1];
                        tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign miso_oe  = (state_q == ACTIVE);
    assign tx_ready = ~hold_full;
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave (responder) for the team's SPI master. Shares the same spcon encoding: bit0 spen, bit1 cpha, bit2 cpol.
- Oversamples sck, ssn and mosi in the clk domain. Shifts one byte in on mosi and one byte out on miso per 8 sck cycles, MSB first.
- Presents received bytes and accepts transmit bytes on a local valid/ready interface.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sck/ssn/mosi (min 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- spcon  in  8  control; [0] spen, [1] cpha, [2] cpol; [7:3] ignored
- sck  in  1  SPI clock from master (asynchronous to clk)
- ssn  in  1  slave select, active low
- mosi  in  1  master-out data
- miso  out  1  slave-out data
- miso_oe  out  1  miso output enable; 1 only while selected
- tx_data  in  8  next byte to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty
- rx_data  out  8  last received byte; held until the next byte completes
- rx_valid  out  1  1-cycle pulse when rx_data updates
- tx_underrun  out  1  1-cycle pulse: byte loaded with hold empty
- frame_abort  out  1  1-cycle pulse: ssn deasserted mid-byte

Behaviour:
Reset values:
- miso=0, miso_oe=0, tx_ready=1, rx_data=0x00, rx_valid=0, tx_underrun=0, frame_abort=0.
- State IDLE, bit_cnt=0.
- Synchronizers reset: sck to 0, ssn to 1, mosi to 0.

Synchronization and timing:
- sck, ssn and mosi pass through SYNC_STAGES flops each, so their relative alignment is preserved.
- Edge detect compares the last synced sample with the previous one.
- Supported timing: sck half-period >= SYNC_STAGES+2 clk cycles. For the master this means spibr >= 3 at default parameters.

Edge classification (ssn low): leading edge = rising if cpol=0, falling if cpol=1; trailing edge = the opposite.
- cpha=0: sample mosi on leading edges; shift miso on trailing edges. The first bit is on miso at selection.
- cpha=1: shift miso on leading edges; sample mosi on trailing edges.
- cpol/cpha are latched on entry to ACTIVE. spcon changes mid-frame are ignored until the next IDLE.

Transmit holding register:
- Write when tx_valid && tx_ready; tx_ready then drops the next cycle.
- A byte load moves hold into the tx shifter and sets tx_ready=1. If hold is empty, the shifter loads 0x00 and tx_underrun pulses.
- Write and load in the same cycle with hold empty: the load gets 0x00 (underrun) and the write fills hold.

State machine:
- IDLE: miso_oe=0. Go to ACTIVE on a synced ssn falling edge with spen=1. On entry: latch the mode, bit_cnt=0, byte load.
  - If cpha=0, miso = MSB of the loaded byte in the entry cycle.
- ACTIVE: miso_oe=1.
  - Sample edge: rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++.
  - On the 8th sample: rx_data <= the shifted byte, rx_valid=1 the next cycle, bit_cnt=0.
  - Shift edge: miso <= next tx bit.
  - Byte boundary with ssn still low (back-to-back): a byte load occurs on the first shift edge of the new byte.
    - cpha=0: this is the trailing edge after the 8th sample; miso takes the new MSB.
    - cpha=1: this is the first leading edge; miso takes the new MSB.
  - Synced ssn rising: to IDLE next cycle. If bit_cnt != 0, pulse frame_abort, discard the partial byte, no rx_valid.
  - spen=0: forced to IDLE immediately, with the same abort rule.
  - sck edges while IDLE are ignored.
- rx has no backpressure; an unread rx_data is overwritten.

Decomposition:
- Package spi_pkg:
  - SPCON bit index constants: SPEN=0, CPHA=1, CPOL=2.
  - State enum: IDLE, ACTIVE.
  - Byte width constant: 8.
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall detect. Instantiated for sck and ssn; the mosi path reuses its sync without edge detect.

Test Plan:
1. Mode 0 (spcon=0x01), hold=0x3C, master sends 0xA5 at spibr=3 -> rx_data=0xA5 with one rx_valid pulse; master receives 0x3C; miso_oe high only while ssn low.
2. Mode 3 (spcon=0x07), hold=0xC3, master sends 0x5A -> rx_data=0x5A; master receives 0xC3; sck idles high; no tx_underrun.
3. Back-to-back: ssn held low for 16 bits, mosi 0x12,0x34, hold written 0x81 then 0x7E after the first tx_ready -> two rx_valid pulses with 0x12 then 0x34; miso carries 0x81 then 0x7E.
4. Underrun: no tx_valid before selection -> tx_underrun pulse at the ssn fall; miso shifts 0x00; rx still completes.
5. Abort: ssn rises after 5 sample edges -> frame_abort pulse, no rx_valid, rx_data keeps its previous value; the next full frame receives correctly.
6. spen dropped mid-byte, and reset asserted mid-byte -> IDLE, miso_oe=0, all outputs at reset/idle values; a subsequent frame works.
